// File: rtl/frame_serializer_arbiter.sv
// frame_serializer_arbiter: round-robin grant of whole frames from N_SRC producers,
// streamed one element per beat to a single downstream valid/ready port.
module frame_serializer_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int N_SRC = 4,
    localparam int SW = $clog2(N_SRC),
    localparam int IW = $clog2(DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  arstn,
    input  logic [N_SRC-1:0]                      src_valid,
    output logic [N_SRC-1:0]                      src_ready,
    input  logic [N_SRC-1:0][DEPTH-1:0][WIDTH-1:0] src_data,
    output logic                                  down_valid,
    input  logic                                  down_ready,
    output logic [WIDTH-1:0]                      down_data,
    output logic [SW-1:0]                         down_src,
    output logic                                  down_last,
    output logic                                  busy
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_nx;
    logic [DEPTH-1:0][WIDTH-1:0] frame;
    logic [SW-1:0] owner, last_grant, gidx, cand;
    logic [IW-1:0] idx;
    logic found, at_last;

    assign at_last = idx == IW'(DEPTH-1);

    // search starts just after the previous winner and wraps back to it
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        cand  = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = SW'((int'(last_grant) + k) % N_SRC);
            if (!found && src_valid[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = (state == IDLE) ? (found ? SEND : IDLE) : ((down_ready && at_last) ? IDLE : SEND);
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            frame      <= '0;
            owner      <= '0;
            last_grant <= SW'(N_SRC-1);
            idx        <= '0;
        end else if (state == IDLE) begin
            if (found) begin
                frame      <= src_data[gidx];
                owner      <= gidx;
                last_grant <= gidx;
                idx        <= '0;
            end
        end else if (down_ready) begin
            idx <= at_last ? '0 : idx + 1'b1;
        end
    end

    always_comb begin
        busy       = state == SEND;
        down_valid = busy;
        src_ready  = (arstn && !busy && found) ? (N_SRC'(1) << gidx) : '0;
        down_data  = busy ? frame[idx] : '0;
        down_src   = owner;
        down_last  = busy && at_last;
    end
endmodule

// File: tb/tb_frame_serializer_arbiter.sv
// tb_frame_serializer_arbiter: scoreboard bench for the round-robin frame serializer.
module tb_frame_serializer_arbiter;
    logic clk = 1'b0;
    logic arstn;
    logic [3:0] src_valid;
    logic [3:0] src_ready;
    logic [3:0][3:0][7:0] src_data;
    logic down_valid, down_ready, down_last, busy;
    logic [7:0] down_data;
    logic [1:0] down_src;
    logic [10:0] sb[$];
    logic [10:0] exp_beat;
    int checks = 0;
    int errors = 0;
    int hs = 0;

    frame_serializer_arbiter #(.WIDTH(8), .DEPTH(4), .N_SRC(4)) dut (
        .clk(clk), .arstn(arstn), .src_valid(src_valid), .src_ready(src_ready),
        .src_data(src_data), .down_valid(down_valid), .down_ready(down_ready),
        .down_data(down_data), .down_src(down_src), .down_last(down_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int s);
        for (int e = 0; e < 4; e++) sb.push_back({2'(s), e == 3, src_data[s][e]});
    endtask

    // present a frame, expect the grant to go to s, then watch DEPTH beats and the gap
    task automatic send(input int s, input logic [3:0] mask, input bit hold);
        src_valid = mask;
        #1;
        chk("grant", 32'(src_ready), 32'(1 << s));
        push_frame(s);
        tick();
        if (!hold) src_valid = '0;
        for (int i = 0; i < 4; i++) begin
            chk("beat_valid", 32'(down_valid), 1);
            chk("busy", 32'(busy), 1);
            tick();
        end
        chk("gap", 32'(down_valid), 0);
    endtask

    always @(negedge clk) begin
        if (arstn && down_valid && down_ready) begin
            hs++;
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_beat = sb.pop_front();
                chk("beat", 32'({down_src, down_last, down_data}), 32'(exp_beat));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        int e, h0;
        arstn = 1'b0;
        src_valid = 4'hF;
        down_ready = 1'b1;
        src_data = '0;
        tick();
        tick();
        chk("rst_ready", 32'(src_ready), 0);
        chk("rst_valid", 32'(down_valid), 0);
        chk("rst_data", 32'(down_data), 0);
        chk("rst_src", 32'(down_src), 0);
        chk("rst_last", 32'(down_last), 0);
        chk("rst_busy", 32'(busy), 0);
        arstn = 1'b1;
        #1;
        chk("rel_ready", 32'(src_ready), 1);
        chk("rel_valid", 32'(down_valid), 0);
        src_valid = '0;

        src_data[2] = {8'h44, 8'h33, 8'h22, 8'h11};
        send(2, 4'b0100, 0);
        chk("sf_drain", 32'(sb.size()), 0);

        for (int s = 0; s < 4; s++) src_data[s] = {4{8'(s)}};
        arstn = 1'b0;
        tick();
        tick();
        arstn = 1'b1;
        for (int f = 0; f < 6; f++) send(f % 4, 4'hF, 1);
        src_valid = '0;
        chk("rr_drain", 32'(sb.size()), 0);

        src_data[2] = {8'hd4, 8'hc3, 8'hb2, 8'ha1};
        src_valid = 4'b0100;
        #1;
        chk("bp_grant", 32'(src_ready), 32'b0100);
        push_frame(2);
        h0 = hs;
        tick();
        src_valid = '0;
        e = 0;
        for (int i = 0; i < 7; i++) begin
            down_ready = pat[i][0];
            #1;
            chk("bp_data", 32'(down_data), 32'(src_data[2][e]));
            chk("bp_src", 32'(down_src), 2);
            chk("bp_last", 32'(down_last), 32'(e == 3));
            tick();
            if (pat[i] != 0) e++;
        end
        down_ready = 1'b1;
        chk("bp_hs", 32'(hs - h0), 4);
        chk("bp_idle", 32'(down_valid), 0);
        chk("bp_drain", 32'(sb.size()), 0);

        src_data[3] = {8'h3d, 8'h3c, 8'h3b, 8'h3a};
        src_data[1] = {8'h1d, 8'h1c, 8'h1b, 8'h1a};
        src_data[0] = {8'h0d, 8'h0c, 8'h0b, 8'h0a};
        send(3, 4'b1000, 0);
        send(1, 4'b0010, 0);
        send(0, 4'b0011, 0);
        chk("sw_drain", 32'(sb.size()), 0);

        src_data[1] = {8'h14, 8'h13, 8'h12, 8'h11};
        src_valid = 4'b0010;
        #1;
        chk("mr_grant", 32'(src_ready), 32'b0010);
        sb.push_back({2'd1, 1'b0, 8'h11});
        sb.push_back({2'd1, 1'b0, 8'h12});
        tick();
        src_valid = '0;
        tick();
        tick();
        #2;
        arstn = 1'b0;
        #1;
        chk("mr_valid", 32'(down_valid), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_data", 32'(down_data), 0);
        chk("mr_drain", 32'(sb.size()), 0);
        tick();
        tick();
        arstn = 1'b1;
        src_data[0] = {8'h08, 8'h07, 8'h06, 8'h05};
        send(0, 4'b0011, 0);
        chk("end_drain", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
